phase_select_mux: RTL and testbench
===================================

// Module: phase_select_mux
// PURPOSE
//  Multi-channel successor to the single quadrant clock mux, with a glitch-free phase-change sequencer.
//  Selects one of NPH oversampled phase taps per channel, all in the clock domain.
//  Selection comes from either a quasi-static select bus (follow mode) or inc/dec step requests (step mode).
//  Sits between the oversampling input stage and the trigger/readout logic. Serves digital phase scans.
// PARAMETERS
//  NCH      4  number of independent channels
//  NPH      4  phase taps per channel; must be a power of 2, at least 2
//  SELW     2  select width per channel; equals log2(NPH)
//  SYNC     3  synchronizer stages on sel_in (at least 2)
//  HOLD     4  output-freeze cycles before a new phase is applied (at least 1)
// PORTS
//  clock        in   1         main clock; all logic on posedge
//  reset_n      in   1         asynchronous reset, active low
//  phase_in     in   NCH*NPH   oversampled taps; channel c tap p = bit c*NPH+p
//  sel_in       in   NCH*SELW  requested phase per channel; quasi-static, may be from another domain
//  step_mode    in   1         0 = follow sel_in; 1 = use step_req/step_dir
//  step_req     in   NCH       one-cycle pulse per channel: move one phase
//  step_dir     in   1         1 = increment, 0 = decrement (sampled together with step_req)
//  data_out     out  NCH       selected tap per channel, registered
//  sel_cur      out  NCH*SELW  phase currently applied per channel
//  busy         out  NCH       channel is in HOLD or APPLY
//  change_done  out  NCH       one-cycle pulse when a new phase is applied
// BEHAVIOUR
//  Reset (async assert; sync release on next clock):
//   - data_out, sel_cur, busy, change_done, sync regs and counters all 0
//   - every channel FSM in IDLE
//  sel_in path: SYNC-flop synchronizer per channel, then a stability register.
//   - The candidate is valid only if the synced value is equal on 2 consecutive cycles.
//   - Single-cycle glitches never start a change.
//  Per-channel FSM: IDLE -> HOLD -> APPLY -> IDLE
//   IDLE:
//    - data_out <= phase_in[sel_cur], 1 clock latency.
//    - Follow mode: a valid candidate != sel_cur latches target and goes to HOLD.
//    - Step mode: step_req latches target = sel_cur +/- 1 modulo NPH (wraps NPH-1 -> 0 and 0 -> NPH-1), goes to HOLD.
//    - Follow mode with candidate == sel_cur: stay in IDLE, no pulse.
//   HOLD:
//    - data_out frozen at its last IDLE value; busy=1.
//    - Stays exactly HOLD cycles, then goes to APPLY.
//   APPLY (1 cycle):
//    - data_out still frozen; busy=1.
//    - sel_cur <= target.
//    - Next cycle: change_done=1 for one clock, busy=0, sel_cur shows the new value.
//    - data_out shows the new tap from the cycle after that (normal 1 clock latency).
//  Request and mode handling:
//   - Target is latched on entry to HOLD. sel_in or step_mode changes during HOLD/APPLY do not alter it.
//   - After return to IDLE, a still-differing follow candidate starts a new change.
//   - step_req while busy, or while step_mode=0, is dropped (no queueing).
//  Channels are fully independent; simultaneous changes on several channels are allowed.
//  Reset asserted mid-HOLD/APPLY aborts the change: sel_cur=0, no change_done.
// TESTING
//  - Reset: hold reset_n=0, drive random inputs -> all outputs 0. Release: ch0 data_out tracks phase_in[0] with 1 clock latency.
//  - Follow: ch1 sel_in 0->2 at cycle T -> busy rises T+SYNC+2. sel_cur=2 and change_done pulse at T+SYNC+HOLD+3. data_out frozen throughout.
//  - Glitch: sel_in ch2 0->3->0, 3 held for 1 cycle after sync -> no busy, sel_cur stays 0.
//  - Step wrap: step_mode=1, sel_cur=3, step_req+dir=1 -> sel_cur=0. Then step_req+dir=0 -> sel_cur=3. One change_done each.
//  - Busy drop: step_req during HOLD -> ignored. Only one change_done; sel_cur moves by exactly 1.
//  - Abort/independence: reset_n=0 mid-HOLD on ch3 -> sel_cur=0, no pulse. Simultaneous ch0/ch1 changes both complete on the same cycle.

Source files
------------

// File: rtl/phase_select_mux.sv
// Per-channel phase-tap selector. Each channel synchronizes its select request
// and runs a HOLD/APPLY sequencer that freezes data_out across every phase change.
module psm_lane #(
  parameter int NPH  = 4,
  parameter int SELW = 2,
  parameter int SYNC = 3,
  parameter int HOLD = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NPH-1:0]  i_taps,
  input  logic [SELW-1:0] i_sel,
  input  logic            i_step_mode,
  input  logic            i_step_req,
  input  logic            i_step_dir,
  output logic            o_data,
  output logic [SELW-1:0] o_sel_cur,
  output logic            o_busy,
  output logic            o_done
);
  localparam int CNTW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_APPLY} state_t;

  state_t                     r_state, w_state_nxt;
  logic [SYNC-1:0][SELW-1:0]  r_sync;
  logic [SELW-1:0]            r_stab;
  logic [SELW-1:0]            r_tgt, w_tgt_nxt;
  logic [SELW-1:0]            r_sel, w_sel_nxt;
  logic [CNTW-1:0]            r_cnt, w_cnt_nxt;
  logic                       r_data, w_data_nxt;
  logic                       r_done, w_done_nxt;
  logic [SELW-1:0]            w_cand;
  logic                       w_cand_vld;

  // A candidate must survive two consecutive synced samples, so one-cycle glitches are ignored.
  assign w_cand     = r_sync[SYNC-1];
  assign w_cand_vld = (w_cand == r_stab);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_stab  <= '0;
      r_tgt   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_data  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC-2:0], i_sel};
      r_stab  <= r_sync[SYNC-1];
      r_tgt   <= w_tgt_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_data_nxt = i_taps[r_sel];
        if (i_step_mode) begin
          if (i_step_req) begin
            // NPH is a power of 2, so SELW-bit arithmetic wraps modulo NPH.
            w_tgt_nxt   = i_step_dir ? r_sel + SELW'(1) : r_sel - SELW'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end else if (w_cand_vld && (w_cand != r_sel)) begin
          w_tgt_nxt   = w_cand;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == CNTW'(HOLD - 1)) w_state_nxt = S_APPLY;
        else                          w_cnt_nxt   = r_cnt + CNTW'(1);
      end
      S_APPLY: begin
        w_sel_nxt   = r_tgt;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_data    = r_data;
  assign o_sel_cur = r_sel;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
endmodule

module phase_select_mux #(
  parameter int NCH  = 4,
  parameter int NPH  = 4,
  parameter int SELW = 2,
  parameter int SYNC = 3,
  parameter int HOLD = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NCH*NPH-1:0]  phase_in,
  input  logic [NCH*SELW-1:0] sel_in,
  input  logic                step_mode,
  input  logic [NCH-1:0]      step_req,
  input  logic                step_dir,
  output logic [NCH-1:0]      data_out,
  output logic [NCH*SELW-1:0] sel_cur,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      change_done
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    psm_lane #(.NPH(NPH), .SELW(SELW), .SYNC(SYNC), .HOLD(HOLD)) u_lane (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_taps      (phase_in[c*NPH +: NPH]),
      .i_sel       (sel_in[c*SELW +: SELW]),
      .i_step_mode (step_mode),
      .i_step_req  (step_req[c]),
      .i_step_dir  (step_dir),
      .o_data      (data_out[c]),
      .o_sel_cur   (sel_cur[c*SELW +: SELW]),
      .o_busy      (busy[c]),
      .o_done      (change_done[c])
    );
  end
endmodule

// File: tb/tb_phase_select_mux.sv
// Directed bench for phase_select_mux: timestamp-based channel model checked every
// cycle, plus literal expectations at the key cycles of each scenario.
module tb_phase_select_mux;
  localparam int NCH = 4, NPH = 4, SELW = 2, SYNC = 3, HOLD = 4;
  localparam int PW = NCH*NPH, SW = NCH*SELW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [PW-1:0] phase_in;
  logic [SW-1:0] sel_in;
  logic          step_mode, step_dir;
  logic [NCH-1:0] step_req;
  logic [NCH-1:0] data_out, busy, change_done;
  logic [SW-1:0] sel_cur;

  int n_checks = 0, n_errors = 0;
  int done_cnt [NCH];

  phase_select_mux #(.NCH(NCH), .NPH(NPH), .SELW(SELW), .SYNC(SYNC), .HOLD(HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .phase_in(phase_in), .sel_in(sel_in),
    .step_mode(step_mode), .step_req(step_req), .step_dir(step_dir),
    .data_out(data_out), .sel_cur(sel_cur), .busy(busy), .change_done(change_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a change accepted at edge e keeps the channel busy until edge e+HOLD+1,
  // where the new phase is applied and change_done pulses.
  int unsigned     edge_n;
  logic [SELW-1:0] m_hist [NCH][SYNC+1];
  int              m_cur [NCH], m_tgt [NCH];
  int unsigned     m_e   [NCH];
  bit              m_act [NCH];
  logic            m_data [NCH], m_done [NCH];

  always @(posedge clock) begin
    if (!reset_n) begin
      edge_n = 0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k <= SYNC; k++) m_hist[c][k] = '0;
        m_cur[c] = 0; m_tgt[c] = 0; m_e[c] = 0; m_act[c] = 0;
        m_data[c] = 1'b0; m_done[c] = 1'b0;
      end
    end else begin
      edge_n++;
      for (int c = 0; c < NCH; c++) begin
        m_done[c] = 1'b0;
        if (m_act[c]) begin
          if (edge_n == m_e[c] + HOLD + 1) begin
            m_cur[c] = m_tgt[c]; m_done[c] = 1'b1; m_act[c] = 0;
          end
        end else begin
          m_data[c] = phase_in[c*NPH + m_cur[c]];
          if (step_mode) begin
            if (step_req[c]) begin
              m_tgt[c] = step_dir ? (m_cur[c] + 1) % NPH : (m_cur[c] + NPH - 1) % NPH;
              m_act[c] = 1; m_e[c] = edge_n;
            end
          end else if (m_hist[c][SYNC-1] == m_hist[c][SYNC] && int'(m_hist[c][SYNC-1]) != m_cur[c]) begin
            m_tgt[c] = int'(m_hist[c][SYNC-1]);
            m_act[c] = 1; m_e[c] = edge_n;
          end
        end
        for (int k = SYNC; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = sel_in[c*SELW +: SELW];
      end
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
    forever begin
      @(posedge clock); #1;
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("model data_out[%0d]", c), 32'(data_out[c]), 32'(m_data[c]));
        chk($sformatf("model sel_cur[%0d]", c), 32'(sel_cur[c*SELW +: SELW]), 32'(m_cur[c]));
        chk($sformatf("model busy[%0d]", c), 32'(busy[c]), 32'(m_act[c]));
        chk($sformatf("model change_done[%0d]", c), 32'(change_done[c]), 32'(m_done[c]));
        if (change_done[c]) done_cnt[c]++;
      end
    end
  end

  task automatic step();
    @(negedge clock);
    phase_in = PW'($urandom);
  endtask

  function automatic int cur(input int c);
    return int'(sel_cur[c*SELW +: SELW]);
  endfunction

  task automatic set_sel(input int c, input int v);
    sel_in[c*SELW +: SELW] = SELW'(v);
  endtask

  logic p0;

  initial begin
    reset_n = 1'b0; phase_in = '0; sel_in = '0; step_mode = 1'b0; step_req = '0; step_dir = 1'b0;

    // Reset with random inputs: everything held at zero.
    for (int i = 0; i < 5; i++) begin
      step();
      sel_in = SW'($urandom); step_req = NCH'($urandom);
      step_mode = 1'($urandom); step_dir = 1'($urandom);
      chk("rst data_out", 32'(data_out), 0);
      chk("rst sel_cur", 32'(sel_cur), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst change_done", 32'(change_done), 0);
    end
    sel_in = '0; step_req = '0; step_mode = 1'b0; step_dir = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p0 = phase_in[0];
      step();
      chk("ch0 track latency", 32'(data_out[0]), 32'(p0));
    end
    repeat (4) step();

    // Follow: ch1 0->2.
    set_sel(1, 2);
    repeat (SYNC + 1) step();
    chk("follow busy early", 32'(busy[1]), 0);
    step();
    chk("follow busy rise", 32'(busy[1]), 1);
    repeat (HOLD) step();
    chk("follow sel before apply", 32'(cur(1)), 0);
    chk("follow busy in apply", 32'(busy[1]), 1);
    step();
    chk("follow sel applied", 32'(cur(1)), 2);
    chk("follow done pulse", 32'(change_done[1]), 1);
    chk("follow busy fall", 32'(busy[1]), 0);
    step();
    chk("follow done one cycle", 32'(change_done[1]), 0);
    repeat (3) step();

    // Glitch: ch2 at 3 for a single cycle.
    set_sel(2, 3);
    step();
    set_sel(2, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch no busy", 32'(busy[2]), 0);
    end
    chk("glitch sel_cur", 32'(cur(2)), 0);

    // Bring ch3 to 3, then step-mode wrap both ways.
    set_sel(3, 3);
    repeat (SYNC + HOLD + 5) step();
    chk("ch3 at 3", 32'(cur(3)), 3);
    done_cnt[3] = 0;
    step_mode = 1'b1; step_dir = 1'b1; step_req = 4'b1000;
    step();
    step_req = '0;
    chk("wrap up busy", 32'(busy[3]), 1);
    repeat (HOLD) step();
    chk("wrap up not yet", 32'(cur(3)), 3);
    step();
    chk("wrap up 3->0", 32'(cur(3)), 0);
    chk("wrap up done", 32'(change_done[3]), 1);
    repeat (2) step();
    step_dir = 1'b0; step_req = 4'b1000;
    step();
    step_req = '0;
    repeat (HOLD + 1) step();
    chk("wrap down 0->3", 32'(cur(3)), 3);
    repeat (3) step();
    chk("wrap done count", 32'(done_cnt[3]), 2);

    // Busy drop: second request during HOLD is ignored.
    done_cnt[0] = 0;
    step_dir = 1'b1; step_req = 4'b0001;
    step();
    step_req = '0;
    step();
    step_req = 4'b0001;
    step();
    step_req = '0;
    repeat (HOLD - 1) step();
    chk("drop sel moved 1", 32'(cur(0)), 1);
    chk("drop done", 32'(change_done[0]), 1);
    repeat (8) step();
    chk("drop sel final", 32'(cur(0)), 1);
    chk("drop done count", 32'(done_cnt[0]), 1);
    chk("drop not busy", 32'(busy[0]), 0);

    // step_req in follow mode is dropped (ch2); ch0 follows sel_in back to 0.
    step_mode = 1'b0; step_req = 4'b0100;
    step();
    step_req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("follow-mode step dropped", 32'(busy[2]), 0);
    end
    repeat (12) step();
    chk("ch0 back to 0", 32'(cur(0)), 0);

    // Abort: reset during ch3 HOLD.
    set_sel(3, 1);
    repeat (SYNC + 3) step();
    chk("abort in hold", 32'(busy[3]), 1);
    reset_n = 1'b0;
    #1;
    chk("abort sel_cur", 32'(sel_cur), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(change_done), 0);
    sel_in = '0;
    repeat (2) step();
    reset_n = 1'b1;
    done_cnt[3] = 0;
    repeat (12) step();
    chk("abort no pulse", 32'(done_cnt[3]), 0);
    chk("abort ch3 sel", 32'(cur(3)), 0);

    // Simultaneous ch0/ch1 changes complete on the same cycle.
    set_sel(0, 2); set_sel(1, 3);
    repeat (SYNC + HOLD + 3) step();
    chk("simul done", 32'(change_done), 32'b0011);
    chk("simul ch0", 32'(cur(0)), 2);
    chk("simul ch1", 32'(cur(1)), 3);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
